itoa_converter: RTL

Hardware itoa block. It takes an unsigned integer and a base (2..10), converts the integer to ASCII digits by repeated division, and emits a byte stream framed by sop/eop.
- The sop beat carries the decimal value of the base.
- The following beats carry the ASCII digits, MSB first; eop is asserted on the last digit.
- This is the transmit side of the team's atoi byte-stream format, so its output feeds the atoi receiver directly.

---
 rtl/itoa_converter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/itoa_converter.sv
// Integer-to-ASCII converter: repeated bit-serial restoring division by the base,
// then a sop/eop-framed byte stream (base byte first, digits MSB first).
module itoa_converter #(
   parameter int NUM_WIDTH  = 32,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_WIDTH-1:0]  number,
   input  logic [DATA_WIDTH-1:0] base,
   input  logic                  start,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  sop,
   output logic                  eop,
   output logic                  error
);

   localparam int BW = $clog2(NUM_WIDTH);
   localparam int CW = $clog2(NUM_WIDTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_DIVIDE, S_EMIT_SOP, S_EMIT_DIG, S_ERR} state_t;

   state_t                r_state, w_state_nxt;
   logic [NUM_WIDTH-1:0]  r_dividend;
   logic [3:0]            r_rem;
   logic [3:0]            r_base;
   logic [BW-1:0]         r_bit;
   logic [CW-1:0]         r_cnt;
   logic [3:0]            r_buf [NUM_WIDTH];
   logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
   logic                  r_sop, w_sop_nxt;
   logic                  r_eop, w_eop_nxt;
   logic                  r_error, w_error_nxt;

   logic [4:0]            w_rem_sh;
   logic                  w_qbit;
   logic [3:0]            w_rem_nxt;
   logic [NUM_WIDTH-1:0]  w_quo;
   logic                  w_last_bit;
   logic                  w_base_ok;
   logic [BW-1:0]         w_pop_idx;
   logic [3:0]            w_digit;

   // Dividend shifts left into the remainder; quotient bits fill in from the LSB,
   // so after NUM_WIDTH steps the dividend register holds the quotient.
   assign w_rem_sh   = {r_rem, r_dividend[NUM_WIDTH-1]};
   assign w_qbit     = (w_rem_sh >= {1'b0, r_base});
   assign w_rem_nxt  = w_qbit ? 4'(w_rem_sh - {1'b0, r_base}) : w_rem_sh[3:0];
   assign w_quo      = {r_dividend[NUM_WIDTH-2:0], w_qbit};
   assign w_last_bit = (r_bit == BW'(NUM_WIDTH - 1));
   assign w_base_ok  = (base >= DATA_WIDTH'(2)) && (base <= DATA_WIDTH'(10));
   assign w_pop_idx  = BW'(r_cnt - CW'(1));
   assign w_digit    = r_buf[w_pop_idx];

   assign ready = (r_state == S_IDLE);
   assign data  = r_data;
   assign sop   = r_sop;
   assign eop   = r_eop;
   assign error = r_error;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Outputs are registered one cycle behind the state that produces them; EMIT_DIG
   // and ERR each hold one extra cycle so ready only returns after the last beat.
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = '0;
      w_sop_nxt   = 1'b0;
      w_eop_nxt   = 1'b0;
      w_error_nxt = 1'b0;
      case (r_state)
         S_IDLE:     if (start) w_state_nxt = w_base_ok ? S_DIVIDE : S_ERR;
         S_DIVIDE:   if (w_last_bit && (w_quo == '0)) w_state_nxt = S_EMIT_SOP;
         S_EMIT_SOP: begin
            w_sop_nxt   = 1'b1;
            w_data_nxt  = DATA_WIDTH'(r_base);
            w_state_nxt = S_EMIT_DIG;
         end
         S_EMIT_DIG: begin
            if (r_cnt != '0) begin
               w_data_nxt = DATA_WIDTH'(8'h30) + DATA_WIDTH'(w_digit);
               w_eop_nxt  = (r_cnt == CW'(1));
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ERR: begin
            if (!r_error) w_error_nxt = 1'b1;
            else          w_state_nxt = S_IDLE;
         end
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data  <= '0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_data  <= w_data_nxt;
         r_sop   <= w_sop_nxt;
         r_eop   <= w_eop_nxt;
         r_error <= w_error_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_dividend <= '0;
         r_rem      <= '0;
         r_base     <= '0;
         r_bit      <= '0;
         r_cnt      <= '0;
         for (int unsigned i = 0; i < NUM_WIDTH; i++) r_buf[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dividend <= number;
                  r_base     <= base[3:0];
                  r_rem      <= '0;
                  r_bit      <= '0;
                  r_cnt      <= '0;
               end
            end
            S_DIVIDE: begin
               r_dividend <= w_quo;
               if (w_last_bit) begin
                  r_buf[BW'(r_cnt)] <= w_rem_nxt;
                  r_cnt             <= r_cnt + CW'(1);
                  r_rem             <= '0;
                  r_bit             <= '0;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_bit <= r_bit + BW'(1);
               end
            end
            S_EMIT_DIG: if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            default: ;
         endcase
      end
   end

endmodule
